transposer_sequencer: RTL
=========================

Name: transposer_sequencer

Overview:
Control and stream front-end for the 32x32 bitslice transposer.
- Accepts 32 words on a valid/ready input stream and writes them into the transposer.
- Then walks the transposer read side and emits 32 results on a valid/ready output stream. Forward direction emits masked/redundant slices; reverse direction emits recovered words.
- Also owns the per-slice randomness handshake and accumulates redundancy-check failures.

Parameters:
NUM_WORDS, 32, words per block and slices per block; fixed by the transposer geometry, only 32 is supported.
CNT_W, 5, width of the beat counter and of the word/bit selects.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  start one block; sampled only in IDLE
dir_i  in  1  0 = forward (words->slices), 1 = reverse (slices->words)
d_cfg_i  in  2  share count code (0:1, 1:2, 2:4)
rs_cfg_i  in  2  spatial redundancy code (0:1, 1:2, 2:4)
comp_i  in  1  complementary redundancy enable
rot_i  in  5  forward slice rotation select
busy_o  out  1  high from start until block done
done_o  out  1  one-cycle pulse after the last output beat
redund_err_o  out  1  sticky: any redundancy failure in the current block
err_cnt_o  out  6  saturating count of failing input beats
in_valid_i / in_ready_o / in_data_i  in/out/in  1/1/32  input stream
out_valid_o / out_ready_i / out_data_o  out/in/out  1/1/32  output stream
rnd_valid_i / rnd_ready_o / rnd_i  in/out/in  1/1/24  randomness stream
tp_data_o  out  32  transposer data_i (equals in_data_i)
tp_word_sel_o  out  5  transposer word_sel_i
tp_write_valid_o  out  1  transposer write_valid_i
tp_clear_mem_o  out  1  transposer clear_mem_i
tp_random_o  out  24  transposer random_i
tp_d_o, tp_rs_o  out  2 each  transposer D_i, R_s_i
tp_bit_sel_o  out  5  transposer bit_sel_i
tp_direction_o, tp_comp_redund_o  out  1 each  transposer direction_i, comp_redund_i
tp_data_i  in  32  transposer data_o
tp_redund_err_i  in  1  transposer redundancy_error_o

Behaviour:
- Reset (rst_i high at a clock edge, any state): state=IDLE, cnt=0, config regs=0, rnd reg empty/0. All outputs 0 except in_ready_o=0 and out_valid_o=0.
- Config latch: dir, d_cfg, rs_cfg, comp and rot are latched on the accepted start. tp_direction_o, tp_d_o, tp_rs_o and tp_comp_redund_o are driven from the latched values at all times.
- IDLE:
  - busy_o=0.
  - If start_i: latch config, clear redund_err_o and err_cnt_o, cnt=0, go to CLEAR.
- CLEAR (exactly 1 cycle): tp_clear_mem_o=1, busy_o=1, go to LOAD.
- LOAD:
  - in_ready_o=1, tp_word_sel_o=cnt, tp_data_o=in_data_i.
  - tp_write_valid_o = in_valid_i (combinational).
  - Each accepted beat: cnt++.
  - Reverse mode only: if tp_redund_err_i is high on an accepted beat, set redund_err_o and increment err_cnt_o (saturates at 63).
  - On beat 31 accepted: cnt=0, go to EMIT.
- EMIT, forward mode:
  - tp_bit_sel_o=cnt, tp_word_sel_o=rot (odd values give no rotation in the transposer).
  - tp_random_o=rnd reg.
  - out_valid_o = (d_cfg==0) or rnd reg full.
  - out_data_o = tp_data_i (combinational passthrough).
- EMIT, reverse mode:
  - tp_word_sel_o=cnt, out_valid_o=1, out_data_o=tp_data_i.
- Rnd reg:
  - rnd_ready_o = EMIT & forward & d_cfg!=0 & reg empty. It loads on rnd handshake.
  - It empties on an output handshake, so each slice gets fresh randomness.
  - Never refilled in the same cycle it is consumed, so there is a 1-cycle bubble per slice when the rnd source is always valid.
  - With d_cfg==0, no randomness is consumed.
- Output stability: while out_valid_o & !out_ready_i, cnt and the rnd reg are held, so out_data_o is stable.
- On beat 31 accepted in EMIT: go to IDLE, done_o=1 for one cycle, busy_o=0 in the same cycle as done_o.
- start_i outside IDLE is ignored. redund_err_o and err_cnt_o hold until the next accepted start.
- No writes in EMIT; tp_write_valid_o=0 outside LOAD.

Decomposition:
- Package transposer_pkg: the seq_state_e enum (IDLE, CLEAR, LOAD, EMIT), the d_cfg and rs_cfg code constants, and NUM_WORDS.
- Sub-module rnd_holder: 24-bit one-entry register with load/consume handshake.

Test Plan:
1. Forward, d=0, rs=0, rot=0, input word i = 32'h1<<i, out_ready=1. Expect start->first out_valid at cycle 34, slices 32'h1<<k in order, done_o pulse, 0 rnd beats.
2. Forward, d=1, rs=1, comp=1, rnd_valid held high with rnd=24'hFFFFFF. Expect exactly 32 rnd handshakes, out_valid with 1-cycle gaps, every slice upper16 == ~lower16.
3. Reverse, d=0, rs=1, comp=0, all 32 beats consistent. Expect redund_err_o=0, err_cnt_o=0. Then inject mismatch on beats 3 and 17: err_cnt_o=2, redund_err_o=1 until the next start.
4. Backpressure: out_ready toggles 1,0,0,1 in EMIT. Expect out_data_o and tp_random_o stable during stalls, no lost or duplicated beats, cnt ends at 31.
5. rst_i asserted mid-LOAD at beat 10. Expect IDLE next cycle, all outputs 0; a new start performs CLEAR and a full 32-beat load.
6. start_i pulsed during LOAD and EMIT. Expect it ignored, config unchanged, exactly one done_o per block.

Source files
------------

// File: rtl/transposer_pkg.sv
// Shared types and constants for the transposer sequencer and its helpers.
package transposer_pkg;

    localparam int NUM_WORDS = 32;
    localparam int CNT_W     = 5;
    localparam int RND_W     = 24;

    localparam logic [1:0] D_CFG_1  = 2'd0;
    localparam logic [1:0] D_CFG_2  = 2'd1;
    localparam logic [1:0] D_CFG_4  = 2'd2;
    localparam logic [1:0] RS_CFG_1 = 2'd0;
    localparam logic [1:0] RS_CFG_2 = 2'd1;
    localparam logic [1:0] RS_CFG_4 = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        EMIT  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/rnd_holder.sv
// One-entry randomness register: filled by the rnd handshake, emptied when the
// slice that used it leaves on the output stream.
module rnd_holder
    import transposer_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_load,
    input  logic [RND_W-1:0] i_data,
    input  logic             i_consume,
    output logic             o_full,
    output logic [RND_W-1:0] o_data
);

    logic             r_full;
    logic [RND_W-1:0] r_data;

    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of the order the simulator evaluates always blocks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_consume) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/transposer_sequencer.sv
// Control and stream front-end for the 32x32 bitslice transposer: loads one
// block of words, then streams slices (forward) or recovered words (reverse).
module transposer_sequencer #(
    parameter int NUM_WORDS = transposer_pkg::NUM_WORDS,
    parameter int CNT_W     = transposer_pkg::CNT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 dir_i,
    input  logic [1:0]           d_cfg_i,
    input  logic [1:0]           rs_cfg_i,
    input  logic                 comp_i,
    input  logic [CNT_W-1:0]     rot_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 redund_err_o,
    output logic [5:0]           err_cnt_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [NUM_WORDS-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [NUM_WORDS-1:0] out_data_o,
    input  logic                 rnd_valid_i,
    output logic                 rnd_ready_o,
    input  logic [23:0]          rnd_i,
    output logic [NUM_WORDS-1:0] tp_data_o,
    output logic [CNT_W-1:0]     tp_word_sel_o,
    output logic                 tp_write_valid_o,
    output logic                 tp_clear_mem_o,
    output logic [23:0]          tp_random_o,
    output logic [1:0]           tp_d_o,
    output logic [1:0]           tp_rs_o,
    output logic [CNT_W-1:0]     tp_bit_sel_o,
    output logic                 tp_direction_o,
    output logic                 tp_comp_redund_o,
    input  logic [NUM_WORDS-1:0] tp_data_i,
    input  logic                 tp_redund_err_i
);

    import transposer_pkg::*;

    seq_state_e       r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir, r_comp, r_redund_err, r_done;
    logic [1:0]       r_d_cfg, r_rs_cfg;
    logic [CNT_W-1:0] r_rot;
    logic [5:0]       r_err_cnt;

    logic             w_last, w_in_hs, w_out_hs;
    logic             w_rnd_needed, w_rnd_full, w_fwd_valid;
    logic [23:0]      w_rnd_data;

    assign w_last       = (r_cnt == CNT_W'(NUM_WORDS - 1));
    assign w_in_hs      = in_valid_i & in_ready_o;
    assign w_out_hs     = out_valid_o & out_ready_i;
    assign w_rnd_needed = !r_dir && (r_d_cfg != D_CFG_1);
    assign w_fwd_valid  = !w_rnd_needed || w_rnd_full;

    rnd_holder u_rnd_holder (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_load    (rnd_valid_i & rnd_ready_o),
        .i_data    (rnd_i),
        .i_consume (w_out_hs & w_rnd_needed),
        .o_full    (w_rnd_full),
        .o_data    (w_rnd_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every output gets a default before the case, so no path through
    // this block leaves a signal unassigned and infers a latch.
    always_comb begin
        w_next_state     = r_state;
        busy_o           = 1'b1;
        in_ready_o       = 1'b0;
        tp_write_valid_o = 1'b0;
        tp_clear_mem_o   = 1'b0;
        tp_word_sel_o    = '0;
        tp_bit_sel_o     = '0;
        out_valid_o      = 1'b0;
        out_data_o       = '0;
        rnd_ready_o      = 1'b0;
        case (r_state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) w_next_state = CLEAR;
            end
            CLEAR: begin
                tp_clear_mem_o = 1'b1;
                w_next_state   = LOAD;
            end
            LOAD: begin
                in_ready_o       = 1'b1;
                tp_word_sel_o    = r_cnt;
                tp_write_valid_o = in_valid_i;
                if (in_valid_i && w_last) w_next_state = EMIT;
            end
            EMIT: begin
                out_data_o = tp_data_i;
                if (r_dir) begin
                    tp_word_sel_o = r_cnt;
                    out_valid_o   = 1'b1;
                end else begin
                    tp_word_sel_o = r_rot;
                    tp_bit_sel_o  = r_cnt;
                    out_valid_o   = w_fwd_valid;
                    rnd_ready_o   = w_rnd_needed && !w_rnd_full;
                end
                if (out_valid_o && out_ready_i && w_last) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt        <= '0;
            r_dir        <= 1'b0;
            r_d_cfg      <= '0;
            r_rs_cfg     <= '0;
            r_comp       <= 1'b0;
            r_rot        <= '0;
            r_redund_err <= 1'b0;
            r_err_cnt    <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start_i) begin
                    r_dir        <= dir_i;
                    r_d_cfg      <= d_cfg_i;
                    r_rs_cfg     <= rs_cfg_i;
                    r_comp       <= comp_i;
                    r_rot        <= rot_i;
                    r_redund_err <= 1'b0;
                    r_err_cnt    <= '0;
                    r_cnt        <= '0;
                end
                LOAD: if (w_in_hs) begin
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    // Redundancy check is only meaningful when slices are written back.
                    if (r_dir && tp_redund_err_i) begin
                        r_redund_err <= 1'b1;
                        if (r_err_cnt != 6'h3F) r_err_cnt <= r_err_cnt + 1'b1;
                    end
                end
                EMIT: if (w_out_hs) begin
                    r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
                    r_done <= w_last;
                end
                default: ;
            endcase
        end
    end

    assign done_o           = r_done;
    assign redund_err_o     = r_redund_err;
    assign err_cnt_o        = r_err_cnt;
    assign tp_data_o        = in_data_i;
    assign tp_random_o      = w_rnd_data;
    assign tp_direction_o   = r_dir;
    assign tp_d_o           = r_d_cfg;
    assign tp_rs_o          = r_rs_cfg;
    assign tp_comp_redund_o = r_comp;

endmodule
